imc_dram_cmd_responder: RTL and testbench

//  DRAM-side responder for the hybrid IMC controller's dram_cmd_* interface. Buffers one-cycle

---
 rtl/imc_dram_cmd_responder_if.sv | 27 ++
 rtl/imc_dram_cmd_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_imc_dram_cmd_responder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imc_dram_cmd_responder_if.sv
// Command/response bus between the IMC controller (master) and the DRAM responder (slave).
interface imc_dram_cmd_responder_if #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NUM_BANKS = 4
) ();
  logic                 cmd_valid;
  logic [1:0]           cmd_type;
  logic [15:0]          cmd_addr;
  logic [DATA_W-1:0]    cmd_wdata;
  logic                 cmd_accum_en;
  logic [NUM_BANKS-1:0] cmd_bank_act;
  logic                 cmd_simul;
  logic                 rsp_valid;
  logic [1:0]           rsp_type;
  logic [DATA_W-1:0]    rsp_data;
  logic                 rsp_err;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_accum_en, cmd_bank_act, cmd_simul,
    input  rsp_valid, rsp_type, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_accum_en, cmd_bank_act, cmd_simul,
    output rsp_valid, rsp_type, rsp_data, rsp_err
  );
endinterface

// File: rtl/imc_dram_cmd_responder.sv
// DRAM-side command responder: command FIFO, open-row/bank-activate model, CAS latency, accumulate.
// Define ACCUM_SAT_EN for a saturating accumulate; otherwise the accumulate wraps.
module imc_dram_cmd_responder #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned COL_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned T_RCD      = 3,
  parameter int unsigned CAS_LAT    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  imc_dram_cmd_responder_if.slave     bus,
  output logic                        busy,
  output logic                        cmd_overflow,
  output logic [15:0]                 row_hits,
  output logic [15:0]                 row_misses
);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned RowW  = AddrW - COL_W;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned BankW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned WaitW = $clog2(T_RCD + CAS_LAT + 1);
  localparam logic [WaitW-1:0] RcdInit = WaitW'(T_RCD - 1);
  localparam logic [WaitW-1:0] CasInit = WaitW'((CAS_LAT >= 2) ? CAS_LAT - 2 : 0);

  localparam logic [1:0] TypeRead  = 2'b00;
  localparam logic [1:0] TypeWrite = 2'b01;
  localparam logic [1:0] TypeAccum = 2'b10;
  localparam logic [1:0] TypePre   = 2'b11;

  typedef struct packed {
    logic [1:0]           typ;
    logic [AddrW-1:0]     addr;
    logic [DATA_W-1:0]    wdata;
    logic                 accum_en;
    logic [NUM_BANKS-1:0] mask;
    logic                 simul;
  } cmd_t;

  typedef enum logic [2:0] {StIdle, StAct, StAccess, StAccWb, StRdWait} state_e;

  state_e            state_q, state_d;
  cmd_t              cur_q, cur_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              open_vld_q, open_vld_d;
  logic [RowW-1:0]   open_row_q, open_row_d;
  logic [NUM_BANKS-1:0] open_mask_q, open_mask_d;
  logic [15:0]       hits_q, hits_d, misses_q, misses_d;
  logic              ovf_q, ovf_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [1:0]        rsp_type_q, rsp_type_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d, rdata_q, rdata_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;

  cmd_t              fifo_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];
  logic [DATA_W-1:0] acc_sum_q [NUM_BANKS];

  cmd_t                 head, fifo_in;
  logic                 empty, full, push, pop;
  logic                 mem_we, wb_sel, acc_we, cur_accum;
  logic [BankW-1:0]     low_idx;
  logic [NUM_BANKS-1:0] tgt_mask;
  logic                 unused_addr;

  function automatic logic [BankW-1:0] lowest_bank(input logic [NUM_BANKS-1:0] m);
    logic [BankW-1:0] idx;
    idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (m[i]) idx = BankW'(i);
    end
    return idx;
  endfunction

  function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef ACCUM_SAT_EN
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
`else
    return s[DATA_W-1:0];
`endif
  endfunction

  assign unused_addr = ^bus.cmd_addr[15:AddrW];
  assign fifo_in     = '{typ: bus.cmd_type, addr: bus.cmd_addr[AddrW-1:0], wdata: bus.cmd_wdata,
                         accum_en: bus.cmd_accum_en, mask: bus.cmd_bank_act,
                         simul: bus.cmd_simul};
  assign head        = fifo_mem[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign full        = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign pop         = (state_q == StIdle) && !empty;
  // A full FIFO still accepts a command in the cycle its head is popped.
  assign push        = bus.cmd_valid && (!full || pop);
  assign low_idx     = lowest_bank(cur_q.mask);
  assign tgt_mask    = cur_q.simul ? cur_q.mask : (NUM_BANKS'(1) << low_idx);
  assign cur_accum   = (cur_q.typ == TypeAccum) || (cur_q.typ == TypeWrite && cur_q.accum_en);

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    wait_d      = wait_q;
    open_vld_d  = open_vld_q;
    open_row_d  = open_row_q;
    open_mask_d = open_mask_q;
    hits_d      = hits_q;
    misses_d    = misses_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_type_d  = 2'b00;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    mem_we      = 1'b0;
    wb_sel      = 1'b0;
    acc_we      = 1'b0;
    ovf_d       = ovf_q | (bus.cmd_valid & ~push);
    wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW+1)'(1);
      2'b01:   count_d = count_q - (PtrW+1)'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          cur_d = head;
          if (head.mask == '0) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_type_d  = head.typ;
          end else if (head.typ == TypePre) begin
            open_vld_d  = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_type_d  = TypePre;
          end else if (open_vld_q && open_row_q == head.addr[AddrW-1:COL_W] &&
                       open_mask_q == head.mask) begin
            hits_d  = (hits_q == 16'hFFFF) ? hits_q : hits_q + 16'd1;
            state_d = StAccess;
          end else begin
            misses_d    = (misses_q == 16'hFFFF) ? misses_q : misses_q + 16'd1;
            open_vld_d  = 1'b1;
            open_row_d  = head.addr[AddrW-1:COL_W];
            open_mask_d = head.mask;
            wait_d      = RcdInit;
            state_d     = StAct;
          end
        end
      end
      StAct: begin
        if (wait_q == '0) state_d = StAccess;
        else wait_d = wait_q - WaitW'(1);
      end
      StAccess: begin
        if (cur_q.typ == TypeRead) begin
          rdata_d = mem[low_idx][cur_q.addr];
          if (CAS_LAT == 1) begin
            rsp_valid_d = 1'b1;
            rsp_type_d  = TypeRead;
            rsp_data_d  = rdata_d;
            state_d     = StIdle;
          end else begin
            wait_d  = CasInit;
            state_d = StRdWait;
          end
        end else if (cur_accum) begin
          acc_we  = 1'b1;
          state_d = StAccWb;
        end else begin
          mem_we      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_type_d  = cur_q.typ;
          state_d     = StIdle;
        end
      end
      StAccWb: begin
        mem_we      = 1'b1;
        wb_sel      = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_type_d  = cur_q.typ;
        rsp_data_d  = acc_sum_q[low_idx];
        state_d     = StIdle;
      end
      StRdWait: begin
        if (wait_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_type_d  = TypeRead;
          rsp_data_d  = rdata_q;
          state_d     = StIdle;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      wait_q      <= '0;
      open_vld_q  <= 1'b0;
      open_row_q  <= '0;
      open_mask_q <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      ovf_q       <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_type_q  <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      wait_q      <= wait_d;
      open_vld_q  <= open_vld_d;
      open_row_q  <= open_row_d;
      open_mask_q <= open_mask_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      ovf_q       <= ovf_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_type_q  <= rsp_type_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage arrays are deliberately not reset; writes are gated by the reset-cleared FSM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= fifo_in;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (acc_we) acc_sum_q[b] <= acc_add(mem[b][cur_q.addr], cur_q.wdata);
      if (mem_we && tgt_mask[b]) mem[b][cur_q.addr] <= wb_sel ? acc_sum_q[b] : cur_q.wdata;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_type  = rsp_type_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != StIdle) || !empty;
  assign cmd_overflow  = ovf_q;
  assign row_hits      = hits_q;
  assign row_misses    = misses_q;
endmodule

// File: tb/tb_imc_dram_cmd_responder.sv
// Self-checking bench: directed latency/boundary cases plus randomized bursts against a
// transaction-level model of banks, open row and hit/miss counts.
module tb_imc_dram_cmd_responder;
  localparam int unsigned DataW = 16;
  localparam int unsigned NumBanks = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, cmd_overflow;
  logic [15:0] row_hits, row_misses;

  imc_dram_cmd_responder_if #(.DATA_W(DataW), .NUM_BANKS(NumBanks)) bus ();

  imc_dram_cmd_responder #(
    .DATA_W(DataW), .NUM_BANKS(NumBanks), .DEPTH(256), .COL_W(4), .FIFO_DEPTH(4),
    .T_RCD(3), .CAS_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .cmd_overflow(cmd_overflow),
    .row_hits(row_hits), .row_misses(row_misses)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what each accepted command must return, in issue order.
  typedef struct {
    logic [1:0]  typ;
    logic [15:0] data;
    logic        err;
  } rsp_t;

  logic [15:0] mmem [NumBanks][256];
  bit          o_vld = 0;
  int          o_row = 0;
  logic [3:0]  o_mask = '0;
  int          m_hits = 0, m_misses = 0;
  rsp_t        exp_q[$];

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef ACCUM_SAT_EN
    if (s > 65535) s = 65535;
`else
    s = s % 65536;
`endif
    return 16'(s);
  endfunction

  task automatic model_cmd(input logic [1:0] typ, input logic [15:0] addr, input logic [15:0] wd,
                           input logic acc, input logic [3:0] mask, input logic simul);
    rsp_t r;
    int   a, row, low;
    r.typ = typ; r.data = 16'h0; r.err = 1'b0;
    a = int'(addr) % 256;
    row = a / 16;
    low = 0;
    for (int b = NumBanks - 1; b >= 0; b--) if (mask[b]) low = b;
    if (mask == 4'h0) begin
      r.err = 1'b1;
    end else if (typ == 2'b11) begin
      o_vld = 0;
    end else begin
      if (o_vld && o_row == row && o_mask == mask) m_hits++;
      else begin
        m_misses++; o_vld = 1; o_row = row; o_mask = mask;
      end
      if (typ == 2'b00) begin
        r.data = mmem[low][a];
      end else begin
        for (int b = 0; b < NumBanks; b++) begin
          if (b == low || (simul && mask[b])) begin
            if (typ == 2'b01 && !acc) mmem[b][a] = wd;
            else begin
              mmem[b][a] = m_add(mmem[b][a], wd);
              if (b == low) r.data = mmem[b][a];
            end
          end
        end
      end
    end
    exp_q.push_back(r);
  endtask

  int unsigned last_issue = 0, last_lat = 0;
  logic [15:0] last_data;
  logic [1:0]  last_type;
  logic        last_err;
  int          rsp_cnt = 0;

  always @(negedge clk) begin
    rsp_t r;
    if (rst_n && bus.rsp_valid) begin
      rsp_cnt++;
      last_lat  = cyc - last_issue;
      last_data = bus.rsp_data;
      last_type = bus.rsp_type;
      last_err  = bus.rsp_err;
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check("rsp_type", 32'(bus.rsp_type), 32'(r.typ));
        check("rsp_data", 32'(bus.rsp_data), 32'(r.data));
        check("rsp_err", 32'(bus.rsp_err), 32'(r.err));
      end
    end
  end

  task automatic send(input logic [1:0] typ, input logic [15:0] addr, input logic [15:0] wd,
                      input logic acc, input logic [3:0] mask, input logic simul, input bit drop);
    bus.cmd_type = typ; bus.cmd_addr = addr; bus.cmd_wdata = wd; bus.cmd_accum_en = acc;
    bus.cmd_bank_act = mask; bus.cmd_simul = simul; bus.cmd_valid = 1'b1;
    last_issue = cyc;
    if (!drop) model_cmd(typ, addr, wd, acc, mask, simul);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) done = 1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_hits"}, 32'(row_hits), 32'(m_hits));
    check({tag, "_misses"}, 32'(row_misses), 32'(m_misses));
  endtask

  int unsigned prev_cnt;
  logic [15:0] exp3;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_type = 2'b00; bus.cmd_addr = 16'h0; bus.cmd_wdata = 16'h0;
    bus.cmd_accum_en = 1'b0; bus.cmd_bank_act = 4'h0; bus.cmd_simul = 1'b0;
    #1;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_rsp_type", 32'(bus.rsp_type), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ovf", 32'(cmd_overflow), 32'd0);
    check_counts("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Miss write: ACCESS in cycle 5, response in cycle 6.
    send(2'b01, 16'h0005, 16'h1234, 1'b0, 4'b0001, 1'b0, 0);
    wait_idle("t1_drain");
    check("t1_lat", last_lat, 32'd6);
    check("t1_misses", 32'(row_misses), 32'd1);
    check_counts("t1");

    send(2'b00, 16'h0005, 16'h0, 1'b0, 4'b0001, 1'b0, 0);
    wait_idle("t2_drain");
    check("t2_lat", last_lat, 32'd4);
    check("t2_data", 32'(last_data), 32'h1234);
    check("t2_hits", 32'(row_hits), 32'd1);

`ifdef ACCUM_SAT_EN
    exp3 = 16'hFFFF;
`else
    exp3 = 16'h0010;
`endif
    send(2'b01, 16'h0005, 16'hFFF0, 1'b0, 4'b0001, 1'b0, 0);
    wait_idle("t3w_drain");
    check("t3w_lat", last_lat, 32'd3);
    send(2'b01, 16'h0005, 16'h0020, 1'b1, 4'b0001, 1'b0, 0);
    wait_idle("t3a_drain");
    check("t3a_lat", last_lat, 32'd4);
    check("t3a_type", 32'(last_type), 32'd1);
    check("t3a_data", 32'(last_data), 32'(exp3));
    send(2'b00, 16'h0005, 16'h0, 1'b0, 4'b0001, 1'b0, 0);
    wait_idle("t3r_drain");
    check("t3r_data", 32'(last_data), 32'(exp3));

    send(2'b01, 16'h0030, 16'h00AA, 1'b0, 4'b1111, 1'b1, 0);
    wait_idle("t4w_drain");
    for (int b = 0; b < NumBanks; b++) begin
      send(2'b00, 16'h0030, 16'h0, 1'b0, 4'(1 << b), 1'b0, 0);
      wait_idle("t4r_drain");
      check("t4_bank_data", 32'(last_data), 32'h00AA);
    end

    send(2'b00, 16'h0030, 16'h0, 1'b0, 4'b0000, 1'b0, 0);
    wait_idle("t6e_drain");
    check("t6_err_lat", last_lat, 32'd2);
    check("t6_err", 32'(last_err), 32'd1);

    // Precharge closes the row, so the same-row read pays T_RCD + CAS_LAT.
    send(2'b11, 16'h0030, 16'h0, 1'b0, 4'b1000, 1'b0, 0);
    wait_idle("t6p_drain");
    send(2'b00, 16'h0030, 16'h0, 1'b0, 4'b1000, 1'b0, 0);
    wait_idle("t6m_drain");
    check("t6_miss_lat", last_lat, 32'd7);
    check("t6_miss_data", 32'(last_data), 32'h00AA);
    check_counts("t6");

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        send(2'b01, 16'(r * 16 + c), 16'($urandom), 1'b0, 4'b1111, 1'b1, 0);
      end
      wait_idle("init_drain");
    end

    for (int n = 0; n < 40; n++) begin
      int len;
      len = int'($urandom_range(1, 4));
      for (int k = 0; k < len; k++) begin
        logic [1:0] t;
        t = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        send(t, {8'($urandom), 2'($urandom), 2'b00, 2'($urandom), 2'($urandom)},
             16'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 0);
      end
      wait_idle("rand_drain");
      check_counts("rand");
    end

    // Overflow: read miss, then five pulses while it is still in flight; the fifth is dropped.
    send(2'b11, 16'h0030, 16'h0, 1'b0, 4'b0001, 1'b0, 0);
    wait_idle("t5p_drain");
    prev_cnt = rsp_cnt;
    send(2'b00, 16'h0030, 16'h0, 1'b0, 4'b0001, 1'b0, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      send(2'b00, 16'h0031, 16'h0, 1'b0, 4'b0001, 1'b0, k == 4);
    end
    wait_idle("t5_drain");
    check("t5_rsp_count", rsp_cnt - prev_cnt, 32'd5);
    check("t5_overflow", 32'(cmd_overflow), 32'd1);
    check_counts("t5");

    send(2'b00, 16'h0000, 16'h0, 1'b0, 4'b0010, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    o_vld = 0; m_hits = 0; m_misses = 0;
    #1;
    check("t6r_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t6r_busy", 32'(busy), 32'd0);
    check("t6r_ovf", 32'(cmd_overflow), 32'd0);
    check_counts("t6r");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("t6r_quiet_busy", 32'(busy), 32'd0);
    send(2'b00, 16'h0030, 16'h0, 1'b0, 4'b0001, 1'b0, 0);
    wait_idle("t6k_drain");
    check_counts("t6k");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end
endmodule
